t_counter: RTL and testbench

T_COUNTER -- requirements
Module: t_counter

---
 rtl/t_counter_pkg.sv | 14 +
 rtl/t_counter_t_stage.sv | 25 ++
 rtl/t_counter.sv | 122 ++++++++++++
 tb/tb_t_counter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/t_counter_pkg.sv
// Shared constants for the T flip-flop up/down counter: direction encodings
// and default geometry.
package t_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_MODULO = 10;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/t_counter_t_stage.sv
// One counter bit: a T flip-flop with synchronous active-high reset and a
// synchronous load path that takes precedence over the toggle.
module t_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/t_counter.sv
// Up/down counter built from WIDTH t_stage bits with a generated toggle chain.
// Define T_COUNTER_MODULO_EN to wrap at MODULO-1 and clamp loads below MODULO.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MODULO = DEF_MODULO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("t_counter: WIDTH must be in 2..16");
    end
    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
        $error("t_counter: MODULO must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] ZERO = '0;
`ifdef T_COUNTER_MODULO_EN
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
`else
    localparam logic [WIDTH-1:0] MAX = '1;
`endif

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] tgl_up;
    logic [WIDTH-1:0] tgl_dn;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] ld_data;
    logic             ld;
    logic             at_max;
    logic             at_zero;
    logic             wrap;

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin : toggle_chain
        logic carry_up;
        logic carry_dn;
        tgl_up   = '0;
        tgl_dn   = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tgl_up[i] = carry_up;
            tgl_dn[i] = carry_dn;
            carry_up  = carry_up & q[i];
            carry_dn  = carry_dn & ~q[i];
        end
    end

    assign at_max  = (q == MAX);
    assign at_zero = (q == ZERO);
    assign wrap    = en && ((up_dn == DIR_UP) ? at_max : at_zero);

`ifdef T_COUNTER_MODULO_EN
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = ({1'b0, load_val} >= (WIDTH+1)'(MODULO)) ? MAX : load_val;

    // A modulo wrap is not a natural binary rollover, so it rides the load path.
    always_comb begin
        ld      = load | wrap;
        ld_data = ZERO;
        if (load) begin
            ld_data = load_clamped;
        end else if (up_dn == DIR_DN) begin
            ld_data = MAX;
        end
    end
`else
    always_comb begin
        ld      = load;
        ld_data = load_val;
    end
`endif

    always_comb begin
        tgl = '0;
        if (!ld && en) begin
            case (up_dn)
                DIR_UP:  tgl = tgl_up;
                DIR_DN:  tgl = tgl_dn;
                default: tgl = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .t     (tgl[i]),
            .ld    (ld),
            .d     (ld_data[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    // tc lines up with the wrapped value appearing on count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc <= 1'b0;
        end else begin
            tc <= wrap & ~load;
        end
    end

    assign count     = q;
    assign count_bar = q_bar;

endmodule

// File: tb/tb_t_counter.sv
// Scoreboard bench for t_counter: the driver queues the expected count/tc for
// every edge, and a negedge monitor pops and compares.
module tb_t_counter;
    import t_counter_pkg::*;

`ifdef T_COUNTER_MODULO_EN
    localparam int  MAXV   = 9;
    localparam bit  MOD_EN = 1'b1;
`else
    localparam int  MAXV   = 15;
    localparam bit  MOD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic [3:0] count_bar;
    logic       tc;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;

    t_counter #(.WIDTH(4), .MODULO(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .count_bar (count_bar),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic ld, input logic e, input logic u,
                        input logic [3:0] lv, input int ec, input logic etc, input string tag);
        @(negedge clk);
        rst = r; load = ld; en = e; up_dn = u; load_val = lv;
        @(posedge clk);
        q_exp.push_back('{cnt: 4'(ec), tc: etc, tag: tag});
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                x = q_exp.pop_front();
                total++;
                if (count !== x.cnt) begin
                    bad++;
                    $display("FAIL %s count: got %0d want %0d", x.tag, count, x.cnt);
                end
                total++;
                if (count_bar !== ~x.cnt) begin
                    bad++;
                    $display("FAIL %s count_bar: got %h want %h", x.tag, count_bar, ~x.cnt);
                end
                total++;
                if (tc !== x.tc) begin
                    bad++;
                    $display("FAIL %s tc: got %b want %b", x.tag, tc, x.tc);
                end
            end
        end
    end

    initial begin : driver
        int         gc;
        int         nc;
        logic       ntc;
        logic       r, ld, e, u;
        logic [3:0] lv;

        // reset dominates load and en
        step(1, 1, 1, DIR_UP, 4'd5, 0, 0, "rst_a");
        step(1, 1, 1, DIR_UP, 4'd5, 0, 0, "rst_b");

        // full up cycle, tc only on the wrap to 0
        for (int i = 1; i <= MAXV + 1; i++)
            step(0, 0, 1, DIR_UP, 4'd0, (i == MAXV + 1) ? 0 : i, (i == MAXV + 1), "up");
        step(0, 0, 1, DIR_UP, 4'd0, 1, 0, "up_after_wrap");
        step(0, 0, 0, DIR_UP, 4'd0, 1, 0, "hold");
        step(0, 0, 0, DIR_DN, 4'd9, 1, 0, "hold_dn");

        // full down cycle from 0, tc at each 0 -> MAX
        step(1, 0, 0, DIR_DN, 4'd0, 0, 0, "rst_c");
        for (int i = 0; i <= MAXV + 1; i++)
            step(0, 0, 1, DIR_DN, 4'd0,
                 (i == 0 || i == MAXV + 1) ? MAXV : MAXV - i,
                 (i == 0 || i == MAXV + 1), "down");

        // load priority and clamping
        step(0, 1, 1, DIR_UP, 4'd12, MOD_EN ? 9 : 12, 0, "load12");
        step(0, 1, 0, DIR_UP, 4'(MAXV), MAXV, 0, "load_max");
        step(0, 1, 1, DIR_UP, 4'd3, 3, 0, "load_beats_wrap");
        step(0, 1, 1, DIR_DN, 4'd15, MOD_EN ? 9 : 15, 0, "load15");

        // direction flip every cycle around 7
        step(0, 1, 0, DIR_UP, 4'd7, 7, 0, "load7");
        step(0, 0, 1, DIR_UP, 4'd0, 8, 0, "flip_up1");
        step(0, 0, 1, DIR_DN, 4'd0, 7, 0, "flip_dn1");
        step(0, 0, 1, DIR_UP, 4'd0, 8, 0, "flip_up2");
        step(0, 0, 1, DIR_DN, 4'd0, 7, 0, "flip_dn2");

        // reset on the would-be wrap edge
        step(0, 1, 0, DIR_UP, 4'(MAXV), MAXV, 0, "pre_wrap");
        step(1, 0, 1, DIR_UP, 4'd0, 0, 0, "rst_at_wrap");
        step(0, 0, 0, DIR_UP, 4'd0, 0, 0, "after_rst_wrap");

        // down through 1 -> 0 -> MAX
        step(0, 1, 0, DIR_DN, 4'd1, 1, 0, "load1");
        step(0, 0, 1, DIR_DN, 4'd0, 0, 0, "dn_to0");
        step(0, 0, 1, DIR_DN, 4'd0, MAXV, 1, "dn_wrap");

        // random traffic against a behavioral golden counter
        step(1, 0, 0, DIR_UP, 4'd0, 0, 0, "rst_d");
        gc = 0;
        for (int k = 0; k < 60; k++) begin
            r  = ($urandom_range(15) == 0);
            ld = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            u  = $urandom_range(1);
            lv = 4'($urandom_range(15));
            ntc = 1'b0;
            if (r) begin
                nc = 0;
            end else if (ld) begin
                nc = (MOD_EN && int'(lv) > MAXV) ? MAXV : int'(lv);
            end else if (e && u) begin
                nc  = (gc == MAXV) ? 0 : gc + 1;
                ntc = (gc == MAXV);
            end else if (e) begin
                nc  = (gc == 0) ? MAXV : gc - 1;
                ntc = (gc == 0);
            end else begin
                nc = gc;
            end
            step(r, ld, e, u, lv, nc, ntc, "golden");
            gc = nc;
        end

        repeat (3) @(negedge clk);
        total++;
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
